// File: rtl/calc_control_seq.sv
// Calculator control path: add/multiply (optional subtract with CALC_SUB_EN), chained operations.
// Latency: add/sub result on the equals/op edge; multiply takes WIDTH cycles with busy=1.
// Backpressure: button presses arriving while busy=1 are dropped.
module calc_control_seq #(
  parameter int WIDTH  = 8,
  parameter int RWIDTH = 2 * WIDTH
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              btn_a,
  input  logic              btn_m,
  input  logic              btn_s,
  input  logic              btn_e,
  input  logic [WIDTH-1:0]  num_in,
  output logic [RWIDTH-1:0] disp,
  output logic              busy,
  output logic              ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_LOAD, S_OPND, S_MUL, S_RES} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_MUL, OP_SUB} op_t;

  state_t state, state_d;
  op_t    op, op_d, new_op;

  logic [RWIDTH-1:0] acc, acc_d, disp_d;
  logic [RWIDTH-1:0] mcand, mcand_d, prod, prod_d;
  logic [WIDTH-1:0]  mplier, mplier_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic              busy_d, ovf_d;
  logic              lost, lost_d, movf, movf_d, after_op, after_op_d;

  logic btn_a_q, btn_m_q, btn_e_q;
  logic press_a, press_m, press_s, press_e, any_op;

  logic [RWIDTH-1:0] opnd;
  logic [RWIDTH:0]   arith, mul_sum;

  assign opnd    = {{(RWIDTH - WIDTH){1'b0}}, num_in};
  assign press_a = btn_a & ~btn_a_q & ~busy;
  assign press_m = btn_m & ~btn_m_q & ~busy;
  assign press_e = btn_e & ~btn_e_q & ~busy;

`ifdef CALC_SUB_EN
  logic btn_s_q;
  assign press_s = btn_s & ~btn_s_q & ~busy;
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) btn_s_q <= 1'b0;
    else        btn_s_q <= btn_s;
  end
`else
  logic unused_btn_s;
  assign unused_btn_s = btn_s;
  assign press_s      = 1'b0;
`endif

  assign any_op  = press_a | press_m | press_s;
  assign new_op  = press_m ? OP_MUL : (press_s ? OP_SUB : OP_ADD);
  assign mul_sum = {1'b0, prod} + {1'b0, mcand};

  // Top bit of arith is carry out for add, borrow for subtract.
  always_comb begin
    arith = {1'b0, acc} + {1'b0, opnd};
`ifdef CALC_SUB_EN
    if (op == OP_SUB) arith = {1'b0, acc} - {1'b0, opnd};
`endif
  end

  always_comb begin
    state_d    = state;
    op_d       = op;
    acc_d      = acc;
    disp_d     = disp;
    ovf_d      = ovf;
    busy_d     = busy;
    mcand_d    = mcand;
    mplier_d   = mplier;
    prod_d     = prod;
    cnt_d      = cnt;
    lost_d     = lost;
    movf_d     = movf;
    after_op_d = after_op;
    case (state)
      S_LOAD: begin
        if (any_op && !press_e) begin
          acc_d   = opnd;
          disp_d  = opnd;
          op_d    = new_op;
          ovf_d   = 1'b0;
          state_d = S_OPND;
        end
      end
      S_OPND: begin
        if (press_e || any_op) begin
          if (!press_e) op_d = new_op;
          if (op == OP_MUL) begin
            mcand_d    = acc;
            mplier_d   = num_in;
            prod_d     = '0;
            cnt_d      = '0;
            lost_d     = 1'b0;
            movf_d     = 1'b0;
            busy_d     = 1'b1;
            after_op_d = ~press_e;
            state_d    = S_MUL;
          end else begin
            acc_d   = arith[RWIDTH-1:0];
            disp_d  = arith[RWIDTH-1:0];
            ovf_d   = arith[RWIDTH];
            state_d = press_e ? S_RES : S_OPND;
          end
        end
      end
      S_MUL: begin
        // lost records multiplicand bits already shifted past the top.
        if (mplier[0]) begin
          prod_d = mul_sum[RWIDTH-1:0];
          movf_d = movf | mul_sum[RWIDTH] | lost;
        end
        lost_d   = lost | mcand[RWIDTH-1];
        mcand_d  = mcand << 1;
        mplier_d = mplier >> 1;
        cnt_d    = cnt + CW'(1);
        if (cnt == CNT_LAST) begin
          acc_d   = prod_d;
          disp_d  = prod_d;
          ovf_d   = movf_d;
          busy_d  = 1'b0;
          state_d = after_op ? S_OPND : S_RES;
        end
      end
      S_RES: begin
        if (any_op && !press_e) begin
          op_d    = new_op;
          ovf_d   = 1'b0;
          state_d = S_OPND;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= S_LOAD;
      op       <= OP_ADD;
      acc      <= '0;
      disp     <= '0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      prod     <= '0;
      cnt      <= '0;
      lost     <= 1'b0;
      movf     <= 1'b0;
      after_op <= 1'b0;
      btn_a_q  <= 1'b0;
      btn_m_q  <= 1'b0;
      btn_e_q  <= 1'b0;
    end else begin
      state    <= state_d;
      op       <= op_d;
      acc      <= acc_d;
      disp     <= disp_d;
      ovf      <= ovf_d;
      busy     <= busy_d;
      mcand    <= mcand_d;
      mplier   <= mplier_d;
      prod     <= prod_d;
      cnt      <= cnt_d;
      lost     <= lost_d;
      movf     <= movf_d;
      after_op <= after_op_d;
      btn_a_q  <= btn_a;
      btn_m_q  <= btn_m;
      btn_e_q  <= btn_e;
    end
  end

endmodule
